cp0_regfile: RTL and testbench

Parametrised MIPS coprocessor-0 register file, the successor to the current CP0 block. It sits beside the pipeline: the EX stage reads it, and the WB stage writes it (MTC0) and reports exceptions and ERET. New in this generation:
- configurable Count prescaler and hardware-interrupt width
- Count/Compare timer interrupt (Cause.TI)
- per-register write masks
- EXL-protected EPC
- a registered-state interrupt request output for the pipeline flush logic

---
 rtl/cp0_regfile.sv | 163 ++++++++++++++++
 tb/tb_cp0_regfile.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// cp0_regfile : MIPS coprocessor-0 registers with Count/Compare timer
// Revision    : 1.0
// ============================================================================
module cp0_regfile #(
  parameter int COUNT_DIV  = 2,
  parameter int HW_INT_NUM = 6,
  parameter bit RD_BYPASS  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic                  exc_badv_we_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           badvaddr_o,
  output logic                  int_req_o,
  output logic                  timer_int_o
);

  localparam logic [31:0] STATUS_RST    = 32'h0040_0000;
  localparam logic [31:0] STATUS_MASK   = 32'h0000_FF03;
  localparam logic [7:0]  PRESC_MAX     = 8'(COUNT_DIV - 1);
  localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  ADDR_EPC      = 5'd14;

  logic [31:0]           badvaddr, count, compare, status, epc, cause;
  logic [7:0]            presc;
  logic                  cause_bd, cause_ti;
  logic [1:0]            ip_sw;
  logic [4:0]            exc_code;
  logic [HW_INT_NUM-1:0] int_q;
  logic [5:0]            hw_ip;

  // Unused hardware IP positions are tied low so they always read 0.
  generate
    if (HW_INT_NUM < 6) begin : g_ip_pad
      assign hw_ip = {{(6 - HW_INT_NUM){1'b0}}, int_q};
    end else begin : g_ip_full
      assign hw_ip = int_q;
    end
  endgenerate

  assign cause = {cause_bd, cause_ti, 14'd0, cause_ti | hw_ip[5], hw_ip[4:0],
                  ip_sw, 1'b0, exc_code, 2'b00};

  logic        wr, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        tick, ti_set;
  logic [31:0] count_inc, status_wr, cause_wr;

  assign wr         = we_i & ~exc_valid_i;
  assign wr_count   = wr && (waddr_i == ADDR_COUNT);
  assign wr_compare = wr && (waddr_i == ADDR_COMPARE);
  assign wr_status  = wr && (waddr_i == ADDR_STATUS);
  assign wr_cause   = wr && (waddr_i == ADDR_CAUSE);
  assign wr_epc     = wr && (waddr_i == ADDR_EPC);
  assign tick       = (presc == PRESC_MAX);
  assign count_inc  = count + 32'd1;
  assign ti_set     = tick & ~wr_count & (count_inc == compare);
  assign status_wr  = (status & ~STATUS_MASK) | (wdata_i & STATUS_MASK);
  assign cause_wr   = {cause[31:10], wdata_i[9:8], cause[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      status   <= STATUS_RST;
      epc      <= '0;
      presc    <= '0;
      cause_bd <= 1'b0;
      cause_ti <= 1'b0;
      ip_sw    <= '0;
      exc_code <= '0;
      int_q    <= '0;
    end else begin
      int_q <= int_i;

      if (wr_count) begin
        count <= wdata_i;
        presc <= '0;
      end else if (tick) begin
        count <= count_inc;
        presc <= '0;
      end else begin
        presc <= presc + 8'd1;
      end

      if (wr_compare) compare <= wdata_i;
      if (wr_compare)  cause_ti <= 1'b0;
      else if (ti_set) cause_ti <= 1'b1;

      if (exc_valid_i) begin
        exc_code <= exc_code_i;
        if (!status[1]) begin
          epc       <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
          cause_bd  <= exc_bd_i;
          status[1] <= 1'b1;
        end
        if (exc_badv_we_i) badvaddr <= exc_badvaddr_i;
      end else begin
        // ERET's EXL clear takes priority over a same-cycle Status write.
        if (wr_status)   status    <= eret_i ? (status_wr & ~32'h0000_0002) : status_wr;
        else if (eret_i) status[1] <= 1'b0;
        if (wr_cause) ip_sw <= wdata_i[9:8];
        if (wr_epc)   epc   <= wdata_i;
      end
    end
  end

  logic [31:0] rd_reg, rd_wr;

  always_comb begin
    rd_reg = '0;
    case (raddr_i)
      ADDR_BADVADDR: rd_reg = badvaddr;
      ADDR_COUNT:    rd_reg = count;
      ADDR_COMPARE:  rd_reg = compare;
      ADDR_STATUS:   rd_reg = status;
      ADDR_CAUSE:    rd_reg = cause;
      ADDR_EPC:      rd_reg = epc;
      default:       rd_reg = '0;
    endcase
    rd_wr = rd_reg;
    case (waddr_i)
      ADDR_COUNT, ADDR_COMPARE, ADDR_EPC: rd_wr = wdata_i;
      ADDR_STATUS:                        rd_wr = status_wr;
      ADDR_CAUSE:                         rd_wr = cause_wr;
      default:                            rd_wr = rd_reg;
    endcase
  end

  assign rdata_o     = (RD_BYPASS && wr && (waddr_i == raddr_i)) ? rd_wr : rd_reg;
  assign count_o     = count;
  assign compare_o   = compare;
  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign badvaddr_o  = badvaddr;
  assign timer_int_o = cause_ti;
  assign int_req_o   = status[0] & ~status[1] & |(status[15:8] & cause[15:8]);

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// ============================================================================
// tb_cp0_regfile : directed and randomized checks against a reference model
// Revision       : 1.0
// ============================================================================
module tb_cp0_regfile;

  localparam int          DIV   = 2;
  localparam logic [31:0] SMASK = 32'h0000_FF03;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0, raddr = '0;
  logic [31:0] wdata = '0;
  logic [5:0]  int_in = '0;
  logic        exc_valid = 1'b0, exc_bd = 1'b0, exc_badv_we = 1'b0, eret = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0, exc_badvaddr = '0;
  logic [31:0] rdata, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
  logic        int_req, timer_int;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_regfile #(.COUNT_DIV(DIV), .HW_INT_NUM(6), .RD_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata), .int_i(int_in),
    .exc_valid_i(exc_valid), .exc_code_i(exc_code), .exc_pc_i(exc_pc),
    .exc_bd_i(exc_bd), .exc_badv_we_i(exc_badv_we), .exc_badvaddr_i(exc_badvaddr),
    .eret_i(eret), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
    .int_req_o(int_req), .timer_int_o(timer_int)
  );

  // Reference model: Count is derived from edges elapsed since its last write.
  logic [31:0] m_base, m_compare, m_status, m_epc, m_badv;
  int unsigned m_cyc;
  logic        m_ti, m_bd;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;
  logic [5:0]  m_int;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_cyc / DIV);
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ti | m_int[5], m_int[4:0], m_ipsw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic m_int_req();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] & ~m_status[1] & |(m_status[15:8] & c[15:8]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count();
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause();
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata();
    logic [31:0] c;
    c = m_cause();
    if (we && !exc_valid && waddr == raddr) begin
      case (raddr)
        5'd9, 5'd11, 5'd14: return wdata;
        5'd12: return (m_status & ~SMASK) | (wdata & SMASK);
        5'd13: return {c[31:10], wdata[9:8], c[7:0]};
        default: return m_read(raddr);
      endcase
    end
    return m_read(raddr);
  endfunction

  task automatic model_reset();
    m_base = 0; m_cyc = 0; m_compare = 0; m_status = 32'h0040_0000;
    m_epc = 0; m_badv = 0; m_ti = 0; m_bd = 0; m_ipsw = 0; m_exc = 0; m_int = 0;
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0; exc_valid = 0; exc_code = 0; exc_pc = 0;
    exc_bd = 0; exc_badv_we = 0; exc_badvaddr = 0; eret = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic step();
    logic wr, cnt_wr, inc;
    logic [31:0] cnt;
    wr     = we && !exc_valid;
    cnt_wr = wr && waddr == 5'd9;
    cnt    = m_count();
    inc    = !cnt_wr && ((m_cyc + 1) % DIV == 0);
    if (wr && waddr == 5'd11) m_ti = 1'b0;
    else if (inc && (cnt + 32'd1) == m_compare) m_ti = 1'b1;
    if (cnt_wr) begin m_base = wdata; m_cyc = 0; end
    else m_cyc = m_cyc + 1;
    if (wr && waddr == 5'd11) m_compare = wdata;
    if (exc_valid) begin
      m_exc = exc_code;
      if (!m_status[1]) begin
        m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
        m_bd = exc_bd;
        m_status[1] = 1'b1;
      end
      if (exc_badv_we) m_badv = exc_badvaddr;
    end else begin
      if (wr && waddr == 5'd12) m_status = (m_status & ~SMASK) | (wdata & SMASK);
      if (wr && waddr == 5'd13) m_ipsw = wdata[9:8];
      if (wr && waddr == 5'd14) m_epc = wdata;
      if (eret) m_status[1] = 1'b0;
    end
    m_int = int_in;
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    step();
    we = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (status_o !== 32'h0040_0000) begin errors++; $display("FAIL reset_status got %h want %h", status_o, 32'h0040_0000); end
    checks++; if (count_o !== 0 || cause_o !== 0 || epc_o !== 0 || compare_o !== 0 || badvaddr_o !== 0) begin errors++; $display("FAIL reset_regs got cnt %h cause %h epc %h cmp %h badv %h want 0", count_o, cause_o, epc_o, compare_o, badvaddr_o); end
    checks++; if (int_req !== 0 || timer_int !== 0) begin errors++; $display("FAIL reset_irq got %b%b want 00", int_req, timer_int); end
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    m_cyc = 1;
  endtask

  task automatic test_masks();
    we = 1; waddr = 12; wdata = 32'hFFFF_FFFF; raddr = 12; #1;
    checks++; if (rdata !== 32'h0040_FF03) begin errors++; $display("FAIL mask_status_bypass got %h want %h", rdata, 32'h0040_FF03); end
    step(); we = 0;
    checks++; if (status_o !== 32'h0040_FF03) begin errors++; $display("FAIL mask_status got %h want %h", status_o, 32'h0040_FF03); end
    mtc0(13, 32'hFFFF_FFFF);
    checks++; if (cause_o !== 32'h0000_0300) begin errors++; $display("FAIL mask_cause got %h want %h", cause_o, 32'h0000_0300); end
    mtc0(8, 32'hDEAD_BEEF);
    checks++; if (badvaddr_o !== 0) begin errors++; $display("FAIL badv_ro got %h want 0", badvaddr_o); end
    mtc0(12, 0); mtc0(13, 0);
  endtask

  task automatic test_prescaler();
    mtc0(9, 0);
    repeat (10) step();
    checks++; if (count_o !== 32'd5) begin errors++; $display("FAIL presc_count got %h want 5", count_o); end
    mtc0(9, 32'hFFFF_FFFF);
    checks++; if (count_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_write got %h want ffffffff", count_o); end
    step(); step();
    checks++; if (count_o !== 0) begin errors++; $display("FAIL count_wrap got %h want 0", count_o); end
  endtask

  task automatic test_timer();
    mtc0(11, 4); mtc0(12, 32'h0000_8001); mtc0(9, 0);
    for (int k = 0; k < 20 && count_o != 4; k++) begin
      checks++; if (timer_int !== 0) begin errors++; $display("FAIL ti_early got %b want 0 at count %h", timer_int, count_o); end
      step();
    end
    checks++; if (count_o !== 4) begin errors++; $display("FAIL ti_count got %h want 4", count_o); end
    checks++; if (timer_int !== 1 || int_req !== 1) begin errors++; $display("FAIL ti_set got ti %b req %b want 1 1", timer_int, int_req); end
    mtc0(11, 100);
    checks++; if (timer_int !== 0 || int_req !== 0) begin errors++; $display("FAIL ti_clear got ti %b req %b want 0 0", timer_int, int_req); end
  endtask

  task automatic test_exception();
    exc_valid = 1; exc_code = 4; exc_pc = 32'hBFC0_0100; exc_bd = 1;
    exc_badv_we = 1; exc_badvaddr = 32'h1235;
    step(); idle();
    checks++; if (epc_o !== 32'hBFC0_00FC) begin errors++; $display("FAIL exc_epc got %h want bfc000fc", epc_o); end
    checks++; if (cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd4) begin errors++; $display("FAIL exc_cause got %h want bd=1 code=4", cause_o); end
    checks++; if (badvaddr_o !== 32'h1235 || status_o[1] !== 1'b1) begin errors++; $display("FAIL exc_badv_exl got %h exl %b want 1235 1", badvaddr_o, status_o[1]); end
    exc_valid = 1; exc_code = 8; exc_pc = 32'h200;
    step(); idle();
    checks++; if (epc_o !== 32'hBFC0_00FC || cause_o[6:2] !== 5'd8) begin errors++; $display("FAIL exc_nested got epc %h code %0d want bfc000fc 8", epc_o, cause_o[6:2]); end
  endtask

  task automatic test_eret();
    int_in = 6'b000001;
    mtc0(12, 32'h0000_0403);
    checks++; if (int_req !== 0) begin errors++; $display("FAIL exl_gate got %b want 0", int_req); end
    eret = 1; step(); eret = 0;
    checks++; if (status_o[1] !== 0 || int_req !== 1) begin errors++; $display("FAIL eret got exl %b req %b want 0 1", status_o[1], int_req); end
    exc_valid = 1; eret = 1; exc_pc = 32'h300; step(); idle();
    checks++; if (status_o[1] !== 1) begin errors++; $display("FAIL exc_eret got exl %b want 1", status_o[1]); end
    int_in = 0;
  endtask

  task automatic test_bypass();
    eret = 1; step(); eret = 0;
    we = 1; waddr = 14; wdata = 32'h1234; raddr = 14; #1;
    checks++; if (rdata !== 32'h1234) begin errors++; $display("FAIL bypass got %h want 1234", rdata); end
    step();
    checks++; if (epc_o !== 32'h1234) begin errors++; $display("FAIL bypass_commit got %h want 1234", epc_o); end
    exc_valid = 1; exc_pc = 32'h8000_0180; exc_bd = 0; #1;
    checks++; if (rdata !== 32'h1234) begin errors++; $display("FAIL bypass_exc_rd got %h want 1234", rdata); end
    step(); idle();
    checks++; if (epc_o !== 32'h8000_0180) begin errors++; $display("FAIL bypass_exc got %h want 80000180", epc_o); end
  endtask

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 5'd8;  1: return 5'd9;  2: return 5'd11; 3: return 5'd12;
      4: return 5'd13; 5: return 5'd14; 6: return 5'd10;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 2) != 0);
      waddr = pick_addr(); raddr = ($urandom_range(0, 2) == 0) ? waddr : pick_addr();
      wdata = $urandom;
      if (waddr == 11 && $urandom_range(0, 1) == 1) wdata = m_count() + 32'($urandom_range(1, 3));
      if (waddr == 12) wdata[1] = ($urandom_range(0, 3) == 0);
      int_in = 6'($urandom);
      exc_valid = ($urandom_range(0, 15) == 0);
      exc_code = 5'($urandom); exc_pc = $urandom; exc_bd = 1'($urandom);
      exc_badv_we = 1'($urandom); exc_badvaddr = $urandom;
      eret = ($urandom_range(0, 7) == 0);
      #1;
      checks++; if (rdata !== m_rdata()) begin errors++; $display("FAIL rnd_rdata[%0d] got %h want %h", i, rdata, m_rdata()); end
      step();
      checks++; if (count_o !== m_count()) begin errors++; $display("FAIL rnd_count[%0d] got %h want %h", i, count_o, m_count()); end
      checks++; if (compare_o !== m_compare) begin errors++; $display("FAIL rnd_compare[%0d] got %h want %h", i, compare_o, m_compare); end
      checks++; if (status_o !== m_status) begin errors++; $display("FAIL rnd_status[%0d] got %h want %h", i, status_o, m_status); end
      checks++; if (cause_o !== m_cause()) begin errors++; $display("FAIL rnd_cause[%0d] got %h want %h", i, cause_o, m_cause()); end
      checks++; if (epc_o !== m_epc) begin errors++; $display("FAIL rnd_epc[%0d] got %h want %h", i, epc_o, m_epc); end
      checks++; if (badvaddr_o !== m_badv) begin errors++; $display("FAIL rnd_badv[%0d] got %h want %h", i, badvaddr_o, m_badv); end
      checks++; if (int_req !== m_int_req() || timer_int !== m_ti) begin errors++; $display("FAIL rnd_irq[%0d] got %b%b want %b%b", i, int_req, timer_int, m_int_req(), m_ti); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    rst = 0; #1;
    model_reset();
    checks++; if (status_o !== 32'h0040_0000 || count_o !== 0 || cause_o !== 0 || epc_o !== 0) begin errors++; $display("FAIL async_reset got st %h cnt %h cause %h epc %h", status_o, count_o, cause_o, epc_o); end
    checks++; if (int_req !== 0 || timer_int !== 0) begin errors++; $display("FAIL async_reset_irq got %b%b want 00", int_req, timer_int); end
    #2; rst = 1;
    step();
    checks++; if (count_o !== m_count() || status_o !== m_status) begin errors++; $display("FAIL post_reset got cnt %h st %h want %h %h", count_o, status_o, m_count(), m_status); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_masks();
    test_prescaler();
    test_timer();
    test_exception();
    test_eret();
    test_bypass();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
